// File: rtl/mem_arb_pkg.sv
// Shared definitions for the fetch/data memory arbiter: FSM state encoding,
// access-size encoding and the default starvation limit.
package mem_arb_pkg;

  // Consecutive data grants tolerated while a fetch is waiting.
  localparam int STARVE_MAX_DEF = 4;

  localparam int ADDR_W  = 64;
  localparam int DATA_W  = 64;
  localparam int INSTR_W = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FE_BUSY  = 2'd1,
    MEM_BUSY = 2'd2,
    FE_DRAIN = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE   = 2'd0,
    SZ_HALF   = 2'd1,
    SZ_WORD   = 2'd2,
    SZ_DOUBLE = 2'd3
  } mem_size_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-client arbiter sharing one downstream memory port between instruction
// fetch and the data memory stage. Data wins ties unless fetch has been
// passed over STARVE_MAX times in a row. A flush cancels a pending or
// in-flight fetch; an in-flight fetch is drained (the port handshake is
// completed) but its data is dropped. Data transactions ignore flush.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  // fetch client
  input  logic               fe_req,
  input  logic [ADDR_W-1:0]  fe_addr,
  output logic               fe_valid,
  output logic [INSTR_W-1:0] fe_rdata,
  // data client
  input  logic               mem_req,
  input  logic               mem_we,
  input  logic [ADDR_W-1:0]  mem_addr,
  input  logic [DATA_W-1:0]  mem_wdata,
  input  logic [1:0]         mem_size,
  output logic               mem_done,
  output logic [DATA_W-1:0]  mem_rdata,
  // pipeline flush
  input  logic               flush,
  // downstream port
  output logic               m_req,
  output logic               m_we,
  output logic [ADDR_W-1:0]  m_addr,
  output logic [DATA_W-1:0]  m_wdata,
  output logic [1:0]         m_size,
  input  logic               m_ack,
  input  logic [DATA_W-1:0]  m_rdata
);

  localparam int              CW      = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(STARVE_MAX);

  arb_state_t    state;
  logic [CW-1:0] starve_cnt;

  logic fe_ok;
  logic pick_mem;
  logic pick_fe;

  // Grant decision for the IDLE state; a flushed fetch is never eligible.
  always_comb begin
    fe_ok    = fe_req && !flush;
    pick_mem = mem_req && !(fe_ok && (starve_cnt == CNT_MAX));
    pick_fe  = fe_ok && !pick_mem;
  end

  // Arbiter FSM, starvation counter and all registered port outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      m_size     <= '0;
      fe_valid   <= 1'b0;
      fe_rdata   <= '0;
      mem_done   <= 1'b0;
      mem_rdata  <= '0;
    end else begin
      // completion strobes are single-cycle pulses
      fe_valid <= 1'b0;
      mem_done <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_mem) begin
            m_req   <= 1'b1;
            m_we    <= mem_we;
            m_addr  <= mem_addr;
            m_wdata <= mem_wdata;
            m_size  <= mem_size;
            state   <= MEM_BUSY;
            // only count grants that actually made a fetch wait
            if (fe_req) begin
              if (starve_cnt != CNT_MAX) starve_cnt <= starve_cnt + 1'b1;
            end else begin
              starve_cnt <= '0;
            end
          end else if (pick_fe) begin
            m_req      <= 1'b1;
            m_we       <= 1'b0;
            m_addr     <= fe_addr;
            m_wdata    <= '0;
            m_size     <= SZ_WORD;
            state      <= FE_BUSY;
            starve_cnt <= '0;
          end
        end
        FE_BUSY: begin
          if (m_ack) begin
            m_req <= 1'b0;
            state <= IDLE;
            // a flush coinciding with the ack still kills the instruction
            if (!flush) begin
              fe_valid <= 1'b1;
              fe_rdata <= m_rdata[INSTR_W-1:0];
            end
          end else if (flush) begin
            state <= FE_DRAIN;
          end
        end
        MEM_BUSY: begin
          if (m_ack) begin
            m_req     <= 1'b0;
            mem_done  <= 1'b1;
            mem_rdata <= m_rdata;
            state     <= IDLE;
          end
        end
        FE_DRAIN: begin
          // finish the downstream handshake, discard the returned word
          if (m_ack) begin
            m_req <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a responder model answers the downstream
// port, and a scoreboard compares grant order/contents and completions
// against expectations queued by the stimulus.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fe_req = 1'b0;
  logic [63:0] fe_addr = '0;
  logic        fe_valid;
  logic [31:0] fe_rdata;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [63:0] mem_addr = '0;
  logic [63:0] mem_wdata = '0;
  logic [1:0]  mem_size = '0;
  logic        mem_done;
  logic [63:0] mem_rdata;
  logic        flush = 1'b0;
  logic        m_req;
  logic        m_we;
  logic [63:0] m_addr;
  logic [63:0] m_wdata;
  logic [1:0]  m_size;
  logic        m_ack = 1'b0;
  logic [63:0] m_rdata = '0;

  int checks = 0;
  int errors = 0;
  int ack_dly = 2;

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic [63:0] wdata;
    logic [1:0]  size;
    bit          is_fe;
  } grant_t;

  typedef struct {
    bit          is_fe;
    logic [63:0] data;
  } done_t;

  grant_t grant_q[$];
  done_t  done_q[$];

  logic [63:0] ml_addr[8];
  logic        ml_we[8];
  logic [63:0] ml_wdata[8];
  logic [1:0]  ml_size[8];

  mem_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .fe_req(fe_req), .fe_addr(fe_addr), .fe_valid(fe_valid), .fe_rdata(fe_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_size(mem_size), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .flush(flush),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_size(m_size),
    .m_ack(m_ack), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  // Memory contents as seen by the responder; low word of 0x1000 is 0x13.
  function automatic logic [63:0] rd_model(input logic [63:0] a);
    return {~a[31:0], a[31:0] ^ 32'h0000_1013};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic exp_fe(input logic [63:0] a, input bit completes);
    grant_t      g;
    done_t       d;
    logic [63:0] r;
    g.addr = a; g.we = 1'b0; g.wdata = '0; g.size = SZ_WORD; g.is_fe = 1'b1;
    grant_q.push_back(g);
    if (completes) begin
      r = rd_model(a);
      d.is_fe = 1'b1;
      d.data  = {32'h0, r[31:0]};
      done_q.push_back(d);
    end
  endtask

  task automatic exp_mem(input int i, input bit completes);
    grant_t g;
    done_t  d;
    g.addr = ml_addr[i]; g.we = ml_we[i]; g.wdata = ml_wdata[i];
    g.size = ml_size[i]; g.is_fe = 1'b0;
    grant_q.push_back(g);
    if (completes) begin
      d.is_fe = 1'b0;
      d.data  = rd_model(ml_addr[i]);
      done_q.push_back(d);
    end
  endtask

  task automatic load(input int i);
    mem_we    = ml_we[i];
    mem_addr  = ml_addr[i];
    mem_wdata = ml_wdata[i];
    mem_size  = ml_size[i];
  endtask

  // Drive n_mem data requests back to back (plus an optional fetch) and
  // drop each request when its completion is seen.
  task automatic run(input int n_mem, input bit fe, input logic [63:0] fa, input int budget);
    int mi = 0;
    bit fe_left = fe;
    bit ok = 1'b0;
    fe_addr = fa;
    fe_req  = fe;
    if (n_mem > 0) begin
      load(0);
      mem_req = 1'b1;
    end
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (fe_valid) begin
        fe_req  = 1'b0;
        fe_left = 1'b0;
      end
      if (mem_done) begin
        mi++;
        if (mi < n_mem) load(mi);
        else mem_req = 1'b0;
      end
      if (!fe_left && mi >= n_mem) begin
        ok = 1'b1;
        break;
      end
    end
    chk("run_complete", ok, 1);
  endtask

  // Downstream responder: ack after ack_dly idle cycles of m_req.
  int rcnt = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      m_ack = 1'b0;
      rcnt  = 0;
    end else if (m_ack) begin
      m_ack = 1'b0;
    end else if (m_req) begin
      if (rcnt >= ack_dly) begin
        m_ack   = 1'b1;
        m_rdata = rd_model(m_addr);
        rcnt    = 0;
      end else begin
        rcnt++;
      end
    end
  end

  // Scoreboard: grant order/contents, port stability, completion data.
  logic        prev_req = 1'b0;
  grant_t      cur;
  done_t       dd;
  logic [1:0]  held_size;
  logic [63:0] held_wdata;
  always @(negedge clk) begin
    if (m_req && !prev_req) begin
      chk("grant_expected", grant_q.size() != 0, 1);
      if (grant_q.size() != 0) begin
        cur = grant_q.pop_front();
        chk("grant_addr", m_addr, cur.addr);
        chk("grant_we", m_we, cur.we);
        if (!cur.is_fe) begin
          chk("grant_size", m_size, cur.size);
          if (cur.we) chk("grant_wdata", m_wdata, cur.wdata);
        end
      end
      held_size  = m_size;
      held_wdata = m_wdata;
    end else if (m_req) begin
      chk("m_addr_held", m_addr, cur.addr);
      chk("m_we_held", m_we, cur.we);
      chk("m_size_held", m_size, held_size);
      chk("m_wdata_held", m_wdata, held_wdata);
    end
    if (fe_valid || mem_done) begin
      chk("single_pulse", fe_valid && mem_done, 0);
      chk("done_expected", done_q.size() != 0, 1);
      if (done_q.size() != 0) begin
        dd = done_q.pop_front();
        chk("done_kind", fe_valid, dd.is_fe);
        if (fe_valid) chk("fe_rdata_sb", fe_rdata, dd.data);
        else          chk("mem_rdata_sb", mem_rdata, dd.data);
      end
    end
    prev_req = m_req;
  end

  initial begin
    bit ok;
    int nd;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_m_req", m_req, 0);
    chk("rst_m_we", m_we, 0);
    chk("rst_fe_valid", fe_valid, 0);
    chk("rst_mem_done", mem_done, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_m_size", m_size, 0);
    chk("rst_fe_rdata", fe_rdata, 0);
    chk("rst_mem_rdata", mem_rdata, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single fetch, ack after a few cycles, one-cycle latencies
    ack_dly = 2;
    exp_fe(64'h1000, 1);
    fe_addr = 64'h1000;
    fe_req  = 1'b1;
    @(negedge clk);
    chk("fe_m_req_latency", m_req, 1);
    chk("fe_m_addr", m_addr, 64'h1000);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      if (m_ack) begin
        ok = 1'b1;
        break;
      end
    end
    chk("fe_ack_seen", ok, 1);
    @(negedge clk);
    chk("fe_valid_k1", fe_valid, 1);
    chk("fe_rdata", fe_rdata, 64'h13);
    fe_req = 1'b0;
    @(negedge clk);
    chk("fe_valid_pulse", fe_valid, 0);

    // simultaneous fetch + load: load first
    ml_addr[0] = 64'h2000; ml_we[0] = 1'b0; ml_wdata[0] = '0; ml_size[0] = SZ_DOUBLE;
    exp_mem(0, 1);
    exp_fe(64'h1100, 1);
    run(1, 1, 64'h1100, 60);

    // starvation: 4 data grants, then fetch, then data resumes
    for (int i = 0; i < 5; i++) begin
      ml_addr[i]  = 64'h5000 + 64'(i * 8);
      ml_we[i]    = (i % 2) == 1;
      ml_wdata[i] = 64'hA000_0000_0000_0000 + 64'(i);
      ml_size[i]  = 2'(i % 4);
    end
    for (int i = 0; i < 4; i++) exp_mem(i, 1);
    exp_fe(64'h1200, 1);
    exp_mem(4, 1);
    run(5, 1, 64'h1200, 300);

    // flush in IDLE: fetch blocked, data still granted
    flush   = 1'b1;
    fe_addr = 64'h1300;
    fe_req  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("flush_idle_no_grant", m_req, 0);
    end
    ml_addr[0] = 64'h6000; ml_we[0] = 1'b0; ml_wdata[0] = '0; ml_size[0] = SZ_WORD;
    exp_mem(0, 1);
    load(0);
    mem_req = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (mem_done) begin
        ok = 1'b1;
        break;
      end
    end
    chk("flush_idle_mem_done", ok, 1);
    mem_req = 1'b0;
    fe_req  = 1'b0;
    flush   = 1'b0;
    @(negedge clk);
    chk("flush_idle_no_fe", m_req, 0);

    // flush during FE_BUSY: drain, no FE_VALID
    ack_dly = 4;
    exp_fe(64'h1400, 0);
    fe_addr = 64'h1400;
    fe_req  = 1'b1;
    @(negedge clk);
    chk("drain_grant", m_req, 1);
    flush  = 1'b1;
    fe_req = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (m_ack) begin
        ok = 1'b1;
        break;
      end
      chk("drain_m_req_held", m_req, 1);
      @(negedge clk);
    end
    chk("drain_ack_seen", ok, 1);
    @(negedge clk);
    chk("drain_m_req_low", m_req, 0);
    chk("drain_no_valid", fe_valid, 0);
    chk("drain_state_idle", dut.state, IDLE);
    repeat (2) begin
      @(negedge clk);
      chk("drain_no_valid_late", fe_valid, 0);
    end

    // flush on the same cycle as the fetch ack
    ack_dly = 1;
    exp_fe(64'h1500, 0);
    fe_addr = 64'h1500;
    fe_req  = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      if (m_ack) begin
        ok = 1'b1;
        break;
      end
    end
    chk("ackflush_ack_seen", ok, 1);
    flush  = 1'b1;
    fe_req = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    chk("ackflush_no_valid", fe_valid, 0);
    chk("ackflush_m_req_low", m_req, 0);
    chk("ackflush_state_idle", dut.state, IDLE);

    // flush during a store: store completes, one MEM_DONE
    ack_dly = 3;
    ml_addr[0] = 64'h3000; ml_we[0] = 1'b1;
    ml_wdata[0] = 64'hDEAD_BEEF_0123_4567; ml_size[0] = SZ_DOUBLE;
    exp_mem(0, 1);
    load(0);
    mem_req = 1'b1;
    @(negedge clk);
    chk("store_grant", m_req, 1);
    flush = 1'b1;
    @(negedge clk);
    chk("store_held_under_flush", m_req, 1);
    @(negedge clk);
    flush = 1'b0;
    nd = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (mem_done) begin
        nd++;
        mem_req = 1'b0;
      end
    end
    chk("store_done_once", nd, 1);

    // reset in the middle of MEM_BUSY
    ack_dly = 10;
    ml_addr[0] = 64'h4000; ml_we[0] = 1'b0; ml_wdata[0] = '0; ml_size[0] = SZ_WORD;
    exp_mem(0, 0);
    load(0);
    mem_req = 1'b1;
    @(negedge clk);
    chk("rstmid_grant", m_req, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_m_req_async", m_req, 0);
    chk("rstmid_m_addr", m_addr, 0);
    chk("rstmid_m_we", m_we, 0);
    chk("rstmid_mem_done", mem_done, 0);
    mem_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (15) begin
      @(negedge clk);
      if (mem_done || fe_valid) nd++;
    end
    chk("rstmid_no_done", nd, 0);

    // normal operation resumes after reset
    ack_dly = 0;
    exp_fe(64'h1600, 1);
    run(0, 1, 64'h1600, 30);

    @(negedge clk);
    chk("grant_q_drained", grant_q.size(), 0);
    chk("done_q_drained", done_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
